// File: rtl/DEF.sv
// DEF: shared ALU types plus the request record used by the ALU arbiter
package DEF;
  typedef logic [63:0] dw;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;
  typedef enum logic {ALU_OP_64, ALU_OP_32} alu_width_e;
  typedef struct packed {
    alu_op_e    alu_op;
    alu_width_e alu_width;
  } alu_control_packet_t;
  localparam int ALU_ARB_TAG_W = 4;
  typedef struct packed {
    alu_control_packet_t        ctrl;
    dw                          op1;
    dw                          op2;
    logic [ALU_ARB_TAG_W-1:0]   tag;
  } alu_req_t;
endpackage

// File: rtl/ALU.sv
// ALU: combinational 64-bit integer ALU; 32-bit ops use the low words and sign-extend
module ALU
  import DEF::*;
(
  input  alu_control_packet_t ctrl,
  input  dw                   op1,
  input  dw                   op2,
  output dw                   result
);
  logic [31:0] a32, b32, r32;
  dw r64;
  assign a32 = op1[31:0];
  assign b32 = op2[31:0];
  always_comb begin
    r64 = '0;
    r32 = '0;
    case (ctrl.alu_op)
      ALU_ADD:  begin r64 = op1 + op2; r32 = a32 + b32; end
      ALU_SUB:  begin r64 = op1 - op2; r32 = a32 - b32; end
      ALU_AND:  begin r64 = op1 & op2; r32 = a32 & b32; end
      ALU_OR:   begin r64 = op1 | op2; r32 = a32 | b32; end
      ALU_XOR:  begin r64 = op1 ^ op2; r32 = a32 ^ b32; end
      ALU_SLL:  begin r64 = op1 << op2[5:0]; r32 = a32 << b32[4:0]; end
      ALU_SRL:  begin r64 = op1 >> op2[5:0]; r32 = a32 >> b32[4:0]; end
      ALU_SRA:  begin r64 = dw'($signed(op1) >>> op2[5:0]); r32 = 32'($signed(a32) >>> b32[4:0]); end
      ALU_SLT:  begin r64 = {63'd0, $signed(op1) < $signed(op2)}; r32 = {31'd0, $signed(a32) < $signed(b32)}; end
      ALU_SLTU: begin r64 = {63'd0, op1 < op2}; r32 = {31'd0, a32 < b32}; end
      default:  ;
    endcase
  end
  assign result = ctrl.alu_width == ALU_OP_32 ? {{32{r32[31]}}, r32} : r64;
endmodule

// File: rtl/rr_pick.sv
// rr_pick: one-hot round-robin pick of the first eligible index at or above prio, with wrap
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] prio,
  output logic [N-1:0]  gnt,
  output logic          vld
);
  logic [N-1:0] rmask, oh;
  // rotate so prio sits at bit 0, take the lowest set bit, rotate back
  assign rmask = N'({elig, elig} >> prio);
  assign oh    = rmask & -rmask;
  assign gnt   = N'(({oh, oh} << prio) >> N);
  assign vld   = |elig;
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one ALU with a single-entry tagged result stage
module alu_share_arb
  import DEF::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  alu_req_t                 req [NUM_REQ],
  input  logic [NUM_REQ-1:0]       flush,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output dw                        rsp_data,
  output logic [ALU_ARB_TAG_W-1:0] rsp_tag
);
  localparam int PW = $clog2(NUM_REQ);
  logic out_valid_q, out_valid_d;
  logic [PW-1:0] out_owner_q, out_owner_d, prio_q, prio_d, g;
  dw out_data_q, out_data_d, alu_res;
  logic [ALU_ARB_TAG_W-1:0] out_tag_q, out_tag_d;
  logic [NUM_REQ-1:0] gnt;
  logic any, free, take;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .elig(req_valid & ~flush),
    .prio(prio_q),
    .gnt (gnt),
    .vld (any)
  );
  always_comb begin
    g = '0;
    for (int i = 0; i < NUM_REQ; i++) g = g | (gnt[i] ? PW'(i) : '0);
  end
  ALU u_alu (
    .ctrl  (req[g].ctrl),
    .op1   (req[g].op1),
    .op2   (req[g].op2),
    .result(alu_res)
  );
  // a flushed owner frees the stage just like a consumed one; its result is dropped
  assign free      = !out_valid_q || rsp_ready[out_owner_q] || flush[out_owner_q];
  assign take      = !rst && free && any;
  assign req_ready = take ? gnt : '0;
  assign rsp_valid = (rst || !out_valid_q) ? '0 : (NUM_REQ'(1) << out_owner_q) & ~flush;
  assign rsp_data  = out_data_q;
  assign rsp_tag   = out_tag_q;
  always_comb begin
    out_valid_d = take || (out_valid_q && !free);
    out_owner_d = take ? g : out_owner_q;
    out_data_d  = take ? alu_res : out_data_q;
    out_tag_d   = take ? req[g].tag : out_tag_q;
    prio_d      = take ? (g == PW'(NUM_REQ - 1) ? '0 : g + 1'b1) : prio_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_owner_q <= '0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      prio_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_owner_q <= out_owner_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      prio_q      <= prio_d;
    end
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: table-driven cycle checks of the shared ALU arbiter with two requesters
module tb_alu_share_arb;
  import DEF::*;
  typedef struct {
    logic        rst;
    logic [1:0]  rv, fl, rr;
    logic [3:0]  op;
    logic        w;
    logic [63:0] a0, b0;
    logic [3:0]  t0;
    logic [63:0] a1, b1;
    logic [3:0]  t1;
    logic [1:0]  e_rdy, e_rsv;
    logic [63:0] e_data;
    logic [3:0]  e_tag;
  } vec_t;
  localparam int NV = 27;
  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, flush, rsp_valid, rsp_ready;
  alu_req_t req [2];
  dw rsp_data;
  logic [ALU_ARB_TAG_W-1:0] rsp_tag;
  int checks = 0;
  int errors = 0;
  vec_t tbl [NV];
  alu_share_arb #(.NUM_REQ(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req      (req),
    .flush    (flush),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_tag  (rsp_tag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int r, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, r, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    rst = v.rst;
    req_valid = v.rv;
    flush = v.fl;
    rsp_ready = v.rr;
    req[0].ctrl.alu_op = alu_op_e'(v.op);
    req[0].ctrl.alu_width = alu_width_e'(v.w);
    req[0].op1 = v.a0;
    req[0].op2 = v.b0;
    req[0].tag = v.t0;
    req[1].ctrl.alu_op = alu_op_e'(v.op);
    req[1].ctrl.alu_width = alu_width_e'(v.w);
    req[1].op1 = v.a1;
    req[1].op2 = v.b1;
    req[1].tag = v.t1;
  endtask
  initial begin
    // reset row, then a single 64-bit ADD 5+7 tag 3
    tbl[0]  = '{1, 2'b11, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 5, 7, 3, 0, 0, 0, 2'b00, 2'b00, 0, 0};
    tbl[1]  = '{0, 2'b01, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 5, 7, 3, 0, 0, 0, 2'b01, 2'b00, 0, 0};
    tbl[2]  = '{0, 2'b00, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 12, 3};
    tbl[3]  = '{1, 2'b00, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 12, 3};
    // fairness: both valid, results 1+1 tag 5 and 10+20 tag 6
    tbl[4]  = '{0, 2'b11, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 1, 1, 5, 10, 20, 6, 2'b01, 2'b00, 0, 0};
    tbl[5]  = '{0, 2'b11, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 1, 1, 5, 10, 20, 6, 2'b10, 2'b01, 2, 5};
    tbl[6]  = '{0, 2'b11, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 1, 1, 5, 10, 20, 6, 2'b01, 2'b10, 30, 6};
    tbl[7]  = '{0, 2'b11, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 1, 1, 5, 10, 20, 6, 2'b10, 2'b01, 2, 5};
    tbl[8]  = '{0, 2'b11, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 1, 1, 5, 10, 20, 6, 2'b01, 2'b10, 30, 6};
    tbl[9]  = '{0, 2'b11, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 1, 1, 5, 10, 20, 6, 2'b10, 2'b01, 2, 5};
    tbl[10] = '{0, 2'b00, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 30, 6};
    // backpressure on a 32-bit SUB 0-1 tag 9; requester 1 waits with 10-3 tag 4
    tbl[11] = '{0, 2'b01, 2'b00, 2'b11, ALU_SUB, ALU_OP_32, 0, 1, 9, 10, 3, 4, 2'b01, 2'b00, 30, 6};
    tbl[12] = '{0, 2'b11, 2'b00, 2'b00, ALU_SUB, ALU_OP_32, 0, 1, 9, 10, 3, 4, 2'b00, 2'b01, M1, 9};
    tbl[13] = '{0, 2'b11, 2'b00, 2'b00, ALU_SUB, ALU_OP_32, 0, 1, 9, 10, 3, 4, 2'b00, 2'b01, M1, 9};
    tbl[14] = '{0, 2'b11, 2'b00, 2'b00, ALU_SUB, ALU_OP_32, 0, 1, 9, 10, 3, 4, 2'b00, 2'b01, M1, 9};
    tbl[15] = '{0, 2'b11, 2'b00, 2'b01, ALU_SUB, ALU_OP_32, 0, 1, 9, 10, 3, 4, 2'b10, 2'b01, M1, 9};
    // flush of in-flight owner 1 with rsp_ready[1]; requester 0 (100+23 tag 2) takes the slot
    tbl[16] = '{0, 2'b01, 2'b10, 2'b10, ALU_ADD, ALU_OP_64, 100, 23, 2, 0, 0, 0, 2'b01, 2'b00, 7, 4};
    // flush on request: requester 1 valid but flushed, stage drains, prio stays at 1
    tbl[17] = '{0, 2'b10, 2'b10, 2'b01, ALU_ADD, ALU_OP_64, 0, 0, 0, 3, 4, 7, 2'b00, 2'b01, 123, 2};
    tbl[18] = '{0, 2'b00, 2'b00, 2'b00, ALU_ADD, ALU_OP_64, 0, 0, 0, 3, 4, 7, 2'b00, 2'b00, 123, 2};
    tbl[19] = '{0, 2'b11, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 1, 1, 5, 3, 4, 7, 2'b10, 2'b00, 123, 2};
    tbl[20] = '{0, 2'b01, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 1, 1, 5, 3, 4, 7, 2'b01, 2'b10, 7, 7};
    // reset mid-flight with prio at 1; first grant afterwards goes to 0
    tbl[21] = '{1, 2'b11, 2'b00, 2'b00, ALU_ADD, ALU_OP_64, 1, 1, 5, 3, 4, 7, 2'b00, 2'b00, 2, 5};
    tbl[22] = '{0, 2'b11, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 1, 1, 5, 3, 4, 7, 2'b01, 2'b00, 0, 0};
    tbl[23] = '{0, 2'b00, 2'b00, 2'b11, ALU_ADD, ALU_OP_64, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2, 5};
    // unknown opcode returns zero with its tag
    tbl[24] = '{0, 2'b01, 2'b00, 2'b11, 4'hF, ALU_OP_64, 5, 7, 8, 0, 0, 0, 2'b01, 2'b00, 2, 5};
    tbl[25] = '{0, 2'b00, 2'b00, 2'b01, ALU_ADD, ALU_OP_64, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 8};
    tbl[26] = '{0, 2'b00, 2'b00, 2'b00, ALU_ADD, ALU_OP_64, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 8};
    apply(tbl[0]);
    repeat (2) @(posedge clk);
    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      apply(tbl[r]);
      #1;
      chk("req_ready", r, 64'(req_ready), 64'(tbl[r].e_rdy));
      chk("rsp_valid", r, 64'(rsp_valid), 64'(tbl[r].e_rsv));
      chk("rsp_data", r, rsp_data, tbl[r].e_data);
      chk("rsp_tag", r, 64'(rsp_tag), 64'(tbl[r].e_tag));
    end
    // single requester 1 continuously valid with draining: granted every cycle, i+1 tag i
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b0;
      req_valid = 2'b10;
      flush = 2'b00;
      rsp_ready = 2'b11;
      req[1].ctrl.alu_op = ALU_ADD;
      req[1].ctrl.alu_width = ALU_OP_64;
      req[1].op1 = 64'(i);
      req[1].op2 = 64'd1;
      req[1].tag = 4'(i);
      #1;
      chk("solo_ready", 100 + i, 64'(req_ready), 64'(2'b10));
      if (i > 0) begin
        chk("solo_valid", 100 + i, 64'(rsp_valid), 64'(2'b10));
        chk("solo_data", 100 + i, rsp_data, 64'(i));
        chk("solo_tag", 100 + i, 64'(rsp_tag), 64'(i - 1));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter sharing one 64-bit integer ALU among `NUM_REQ` requesters, e.g. the execute pipe and a CSR/address helper. It accepts at most one operation per cycle and drives the existing `ALU` combinationally from the granted request. The result is registered into a single-entry output stage that is returned to the owning requester with its tag. Ready/valid handshakes on both sides and a per-requester flush make it safe to place between pipeline stages that can stall or be squashed.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input [NUM_REQ]: request present.
- `req_ready` output [NUM_REQ]: request accepted this cycle; one-hot or zero.
- `req` input alu_req_t [NUM_REQ]: {ctrl alu_control_packet_t, op1 dw, op2 dw, tag logic [ALU_ARB_TAG_W-1:0]}.
- `flush` input [NUM_REQ]: squash that requester's in-flight result and block its grant this cycle.
- `rsp_valid` output [NUM_REQ]: result valid for requester i; at most one bit set.
- `rsp_ready` input [NUM_REQ]: requester i consumes its result.
- `rsp_data` output dw: 64-bit result, already width-adjusted (32-bit ops sign-extended).
- `rsp_tag` output [ALU_ARB_TAG_W]: tag of the result.

## Operation
- State:
  - `out_valid` (1 bit), `out_owner` (log2 NUM_REQ bits), `out_data`, `out_tag`.
  - `prio`, the round-robin pointer (log2 NUM_REQ bits).
- Eligibility: requester i is eligible when `req_valid[i] && !flush[i]`.
- Stage free: `free = !out_valid || (rsp_ready[out_owner] && !... )` simplified to: `!out_valid || rsp_ready[out_owner] || flush[out_owner]`.
- Grant: when `free`, grant the first eligible index starting at `prio`, searching upward with wrap; `req_ready[g] = 1`. When not `free`, all `req_ready` are 0.
- On grant:
  - `out_valid <= 1`, `out_owner <= g`, `out_data <= ALU(req[g])`, `out_tag <= req[g].tag`.
  - `prio <= (g+1) mod NUM_REQ`.
- No grant and stage drained or flushed: `out_valid <= 0`. `prio` is unchanged.
- Output decode: `rsp_valid[i] = out_valid && out_owner==i && !flush[i]`. `rsp_data` and `rsp_tag` are driven from the registers regardless of valid.
- Flush priority: flush on the owner beats `rsp_ready` in the same cycle. The result is dropped, never delivered.
- Unknown `alu_op`: result is 0 (ALU default) and is still returned with its tag.
- ALU operand, shift and width rules are entirely the ALU's. This block never modifies operands.

## Timing
- Reset: `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_tag=0`, `out_owner=0`, `prio=0`.
- Latency:
  - Accepted in cycle N → `rsp_valid` in cycle N+1.
  - The result is held stable until cycle M where `rsp_ready[out_owner]` or `flush[out_owner]` is high.
- Throughput: 1 op/cycle when the owner drains every cycle; back-to-back accept and drain in the same cycle is required.
- `req_ready` depends combinationally on `req_valid`, `flush`, `rsp_ready` and state. Requesters must not make `req_valid` depend on `req_ready`.
- Stall: once asserted, `req_valid` and the `req` payload are held by the requester until accepted. The arbiter may grant another requester meanwhile.
- Reset mid-operation: the in-flight result is discarded with no `rsp_valid` in the following cycle. `prio` returns to 0.
- Single requester continuously valid with the stage draining: granted every cycle. `prio` toggles past it and its wrap keeps it granted.

## Structure
- Package `DEF` gains:
  - `ALU_ARB_TAG_W` (default 4).
  - `alu_req_t` packed struct.
- The block reuses the package's existing `dw`, `alu_control_packet_t` and ALU op/width enums.
- Sub-modules:
  - The existing `ALU`, instantiated once on the granted request (mux before the ALU).
  - `rr_pick` (combinational): the eligible mask plus `prio` in, a one-hot grant and a valid flag out.
- Target 150–250 lines of RTL total.

## Test plan
- **Reset, then one ADD.** Requester 0: `op1=5`, `op2=7`, tag 3, `ALU_OP_64`.
  - `req_ready[0]` is high that cycle.
  - Next cycle: `rsp_valid[0]`, `rsp_data=12`, `rsp_tag=3`.
  - Outputs are zero during reset.
- **Fairness.** Both requesters valid for 6 cycles, `rsp_ready` always high.
  - Grants alternate 0,1,0,1,0,1.
  - Responses carry the matching tags, 1/cycle.
- **Backpressure.** `rsp_ready[0]=0` for 3 cycles after a 32-bit SUB with `op1=0`, `op2=1`.
  - `rsp_data=0xFFFF_FFFF_FFFF_FFFF` held stable.
  - All `req_ready` are 0 during the stall.
  - Accept resumes the cycle `rsp_ready[0]` rises.
- **Flush.** Requester 1 in flight and requester 0 waiting; `flush[1]` and `rsp_ready[1]` both asserted in the same cycle.
  - No `rsp_valid[1]` that cycle.
  - `req_ready[0]=1` that cycle.
  - Requester 0's result appears next cycle.
- **Flush on request.** `req_valid[1]` and `flush[1]` both high, requester 0 idle.
  - No grant.
  - `out_valid` goes 0.
  - `prio` is unchanged.
- **Reset mid-flight.** `rst` asserted the cycle after accept.
  - `rsp_valid=0` afterward.
  - The first post-reset grant goes to index 0 when both requesters are valid.
